// File: rtl/sfx_pkg.sv
// Shared types and melody tables for the win/loss jingle sequencer.
// Half periods are counted in sample ticks; entry 0 is the first note played.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    typedef enum logic {
        MEL_VICTORY = 1'b0,
        MEL_DEFEAT  = 1'b1
    } melody_t;

    localparam int HP_W = 7;

    // C5 E5 G5 C6 and G4 E4 C4; the unused fourth defeat slot is never indexed
    localparam logic [3:0][HP_W-1:0] VIC_HP = {7'd23, 7'd31, 7'd36, 7'd46};
    localparam logic [3:0][HP_W-1:0] DEF_HP = {7'd92, 7'd92, 7'd73, 7'd61};

    localparam int VIC_NOTES = 4;
    localparam int DEF_NOTES = 3;

    function automatic logic [HP_W-1:0] half_period(input melody_t m, input logic [1:0] idx);
        return (m == MEL_VICTORY) ? VIC_HP[idx] : DEF_HP[idx];
    endfunction

    function automatic logic [1:0] last_note(input melody_t m);
        return (m == MEL_VICTORY) ? 2'(VIC_NOTES - 1) : 2'(DEF_NOTES - 1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: one-cycle tick at the terminal count.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 1042
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (r_cnt == TERM)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = (r_cnt == TERM);

endmodule

// File: rtl/game_sfx_gen.sv
// Win/loss jingle sequencer: square-wave notes written to the codec port,
// one sample per accepted tick, holding write until the codec takes it.
module game_sfx_gen
    import sfx_pkg::*;
#(
    parameter int                SAMPLE_DIV   = 1042,
    parameter int                DATA_W       = 24,
    parameter logic [DATA_W-1:0] AMPL         = DATA_W'(24'h100000),
    parameter int                NOTE_SAMPLES = 7200
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              victory,
    input  logic              done,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy
);

    localparam int NCW = (NOTE_SAMPLES > 1) ? $clog2(NOTE_SAMPLES) : 1;
    localparam logic [NCW-1:0]    NOTE_LAST = NCW'(NOTE_SAMPLES - 1);
    localparam logic [DATA_W-1:0] NEG_AMPL  = (~AMPL) + {{(DATA_W-1){1'b0}}, 1'b1};

    logic w_tick;

    sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .tick     (w_tick)
    );

    // r_arm masks the first cycle after reset so a level held through reset
    // is not mistaken for a fresh win/loss.
    logic r_vic_q, r_done_q, r_arm;
    logic w_vic_rise, w_done_rise;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_vic_q  <= 1'b0;
            r_done_q <= 1'b0;
            r_arm    <= 1'b0;
        end else begin
            r_vic_q  <= victory;
            r_done_q <= done;
            r_arm    <= 1'b1;
        end
    end

    assign w_vic_rise  = r_arm & victory & ~r_vic_q;
    assign w_done_rise = r_arm & done & ~r_done_q;

    state_t            r_state;
    melody_t           r_mel;
    logic [1:0]        r_note_idx;
    logic [NCW-1:0]    r_note_cnt;
    logic [HP_W-1:0]   r_half_cnt;
    logic              r_pol;
    logic              r_last;
    logic              r_write;
    logic              r_busy;
    logic [DATA_W-1:0] r_data;

    logic [HP_W-1:0] w_hp;
    logic            w_note_end;
    logic            w_half_end;
    logic            w_last_note;

    assign w_hp        = half_period(r_mel, r_note_idx);
    assign w_note_end  = (r_note_cnt == NOTE_LAST);
    assign w_half_end  = (r_half_cnt == w_hp - 7'd1);
    assign w_last_note = (r_note_idx == last_note(r_mel));

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_mel      <= MEL_VICTORY;
            r_note_idx <= '0;
            r_note_cnt <= '0;
            r_half_cnt <= '0;
            r_pol      <= 1'b1;
            r_last     <= 1'b0;
            r_write    <= 1'b0;
            r_busy     <= 1'b0;
            r_data     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_vic_rise || w_done_rise) begin
                        r_mel      <= w_vic_rise ? MEL_VICTORY : MEL_DEFEAT;
                        r_note_idx <= '0;
                        r_note_cnt <= '0;
                        r_half_cnt <= '0;
                        r_pol      <= 1'b1;
                        r_last     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= PLAY;
                    end
                end
                PLAY: begin
                    if (w_tick) begin
                        r_data  <= r_pol ? AMPL : NEG_AMPL;
                        r_write <= 1'b1;
                        r_state <= WAIT_RDY;
                        if (w_note_end) begin
                            r_note_idx <= r_note_idx + 1'b1;
                            r_note_cnt <= '0;
                            r_half_cnt <= '0;
                            r_pol      <= 1'b1;
                            r_last     <= w_last_note;
                        end else begin
                            r_note_cnt <= r_note_cnt + 1'b1;
                            if (w_half_end) begin
                                r_pol      <= ~r_pol;
                                r_half_cnt <= '0;
                            end else begin
                                r_half_cnt <= r_half_cnt + 1'b1;
                            end
                        end
                    end
                end
                WAIT_RDY: begin
                    // Ticks seen here are dropped; only one sample is ever in flight.
                    if (write_ready) begin
                        r_write <= 1'b0;
                        if (r_last) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= PLAY;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign write           = r_write;
    assign writedata_left  = r_data;
    assign writedata_right = r_data;
    assign busy            = r_busy;

endmodule
